// File: rtl/cache_bus_arbiter.sv
// Round-robin arbiter merging icache/dcache request channels onto one memory port, one transaction in flight.
// Optional return watchdog enabled by defining CACHE_BUS_ARB_TIMEOUT_EN.
module cache_bus_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 128,
    parameter int ID_W    = 8,
    parameter int ERR_W   = 4,
    parameter int TMO_CYC = 256
) (
    input  logic              clk_i,
    input  logic              srst_i,
    // icache request channel
    input  logic              ic_req_valid_i,
    output logic              ic_req_full_o,
    input  logic [ADDR_W-1:0] ic_req_addr_i,
    input  logic [ID_W-1:0]   ic_req_id_i,
    input  logic [4:0]        ic_req_opcode_i,
    input  logic [4:0]        ic_req_funct_i,
    input  logic [DATA_W-1:0] ic_req_wdata_i,
    input  logic              ic_req_ci_i,
    input  logic              ic_req_wt_i,
    input  logic [ERR_W-1:0]  ic_req_error_i,
    // dcache request channel
    input  logic              dc_req_valid_i,
    output logic              dc_req_full_o,
    input  logic [ADDR_W-1:0] dc_req_addr_i,
    input  logic [ID_W-1:0]   dc_req_id_i,
    input  logic [4:0]        dc_req_opcode_i,
    input  logic [4:0]        dc_req_funct_i,
    input  logic [DATA_W-1:0] dc_req_wdata_i,
    input  logic              dc_req_ci_i,
    input  logic              dc_req_wt_i,
    input  logic [ERR_W-1:0]  dc_req_error_i,
    // master return channels
    output logic              ic_rtn_valid_o,
    output logic [ID_W-1:0]   ic_rtn_id_o,
    output logic [ERR_W-1:0]  ic_rtn_error_o,
    output logic              ic_rtn_mmio_o,
    output logic [DATA_W-1:0] ic_rtn_rdata_o,
    output logic              dc_rtn_valid_o,
    output logic [ID_W-1:0]   dc_rtn_id_o,
    output logic [ERR_W-1:0]  dc_rtn_error_o,
    output logic              dc_rtn_mmio_o,
    output logic [DATA_W-1:0] dc_rtn_rdata_o,
    // memory side
    output logic              mem_req_valid_o,
    input  logic              mem_req_full_i,
    output logic [ADDR_W-1:0] mem_req_addr_o,
    output logic [ID_W-1:0]   mem_req_id_o,
    output logic [4:0]        mem_req_opcode_o,
    output logic [4:0]        mem_req_funct_o,
    output logic [DATA_W-1:0] mem_req_wdata_o,
    output logic              mem_req_ci_o,
    output logic              mem_req_wt_o,
    output logic [ERR_W-1:0]  mem_req_error_o,
    input  logic              mem_rtn_valid_i,
    input  logic [ID_W-1:0]   mem_rtn_id_i,
    input  logic [ERR_W-1:0]  mem_rtn_error_i,
    input  logic              mem_rtn_mmio_i,
    input  logic [DATA_W-1:0] mem_rtn_rdata_i,
    output logic              stray_rtn_o,
    output logic [1:0]        state_o
);

    // Handshake: a request transfers in any cycle where valid=1 and full=0
    // (both on the request side and on the memory side); returns have no backpressure.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_dc_q;
    logic   owner_dc_q;
    logic   ic_win, dc_win, accept;

    logic              rtn_fire;
    logic [ID_W-1:0]   rtn_id_n;
    logic [ERR_W-1:0]  rtn_error_n;
    logic              rtn_mmio_n;
    logic [DATA_W-1:0] rtn_rdata_n;

`ifdef CACHE_BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TMO_CYC + 1);
    logic [CNT_W-1:0] tmo_cnt_q;
`endif

    always_comb begin
        state_d     = state_q;
        ic_win      = 1'b0;
        dc_win      = 1'b0;
        rtn_fire    = 1'b0;
        rtn_id_n    = mem_rtn_id_i;
        rtn_error_n = mem_rtn_error_i;
        rtn_mmio_n  = mem_rtn_mmio_i;
        rtn_rdata_n = mem_rtn_rdata_i;
        case (state_q)
            IDLE: begin
                // On a tie the master that did not win last time goes first.
                ic_win = ic_req_valid_i & (~dc_req_valid_i | last_dc_q);
                dc_win = dc_req_valid_i & (~ic_req_valid_i | ~last_dc_q);
                if (ic_win | dc_win) state_d = ISSUE;
            end
            ISSUE: begin
                if (!mem_req_full_i) state_d = WAIT;
            end
            WAIT: begin
                if (mem_rtn_valid_i) begin
                    rtn_fire = 1'b1;
                    state_d  = IDLE;
                end
`ifdef CACHE_BUS_ARB_TIMEOUT_EN
                else if (tmo_cnt_q == CNT_W'(TMO_CYC - 1)) begin
                    rtn_fire    = 1'b1;
                    rtn_id_n    = mem_req_id_o;
                    rtn_error_n = '1;
                    rtn_mmio_n  = 1'b0;
                    rtn_rdata_n = '0;
                    state_d     = IDLE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept          = ic_win | dc_win;
    assign ic_req_full_o   = ~ic_win;
    assign dc_req_full_o   = ~dc_win;
    assign mem_req_valid_o = (state_q == ISSUE);
    assign state_o         = state_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q          <= IDLE;
            last_dc_q        <= 1'b1;
            owner_dc_q       <= 1'b0;
            mem_req_addr_o   <= '0;
            mem_req_id_o     <= '0;
            mem_req_opcode_o <= '0;
            mem_req_funct_o  <= '0;
            mem_req_wdata_o  <= '0;
            mem_req_ci_o     <= 1'b0;
            mem_req_wt_o     <= 1'b0;
            mem_req_error_o  <= '0;
            ic_rtn_valid_o   <= 1'b0;
            ic_rtn_id_o      <= '0;
            ic_rtn_error_o   <= '0;
            ic_rtn_mmio_o    <= 1'b0;
            ic_rtn_rdata_o   <= '0;
            dc_rtn_valid_o   <= 1'b0;
            dc_rtn_id_o      <= '0;
            dc_rtn_error_o   <= '0;
            dc_rtn_mmio_o    <= 1'b0;
            dc_rtn_rdata_o   <= '0;
            stray_rtn_o      <= 1'b0;
        end else begin
            state_q        <= state_d;
            ic_rtn_valid_o <= 1'b0;
            dc_rtn_valid_o <= 1'b0;
            // Any return not expected in WAIT is dropped and flagged.
            stray_rtn_o    <= mem_rtn_valid_i && (state_q != WAIT);
            if (accept) begin
                owner_dc_q       <= dc_win;
                last_dc_q        <= dc_win;
                mem_req_addr_o   <= dc_win ? dc_req_addr_i   : ic_req_addr_i;
                mem_req_id_o     <= dc_win ? dc_req_id_i     : ic_req_id_i;
                mem_req_opcode_o <= dc_win ? dc_req_opcode_i : ic_req_opcode_i;
                mem_req_funct_o  <= dc_win ? dc_req_funct_i  : ic_req_funct_i;
                mem_req_wdata_o  <= dc_win ? dc_req_wdata_i  : ic_req_wdata_i;
                mem_req_ci_o     <= dc_win ? dc_req_ci_i     : ic_req_ci_i;
                mem_req_wt_o     <= dc_win ? dc_req_wt_i     : ic_req_wt_i;
                mem_req_error_o  <= dc_win ? dc_req_error_i  : ic_req_error_i;
            end
            if (rtn_fire) begin
                if (owner_dc_q) begin
                    dc_rtn_valid_o <= 1'b1;
                    dc_rtn_id_o    <= rtn_id_n;
                    dc_rtn_error_o <= rtn_error_n;
                    dc_rtn_mmio_o  <= rtn_mmio_n;
                    dc_rtn_rdata_o <= rtn_rdata_n;
                end else begin
                    ic_rtn_valid_o <= 1'b1;
                    ic_rtn_id_o    <= rtn_id_n;
                    ic_rtn_error_o <= rtn_error_n;
                    ic_rtn_mmio_o  <= rtn_mmio_n;
                    ic_rtn_rdata_o <= rtn_rdata_n;
                end
            end
        end
    end

`ifdef CACHE_BUS_ARB_TIMEOUT_EN
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            tmo_cnt_q <= '0;
        end else if (state_q == ISSUE) begin
            tmo_cnt_q <= '0;
        end else if (state_q == WAIT) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end
`endif

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!srst_i && accept &&
            $isunknown(dc_win ? {dc_req_ci_i, dc_req_wt_i} : {ic_req_ci_i, ic_req_wt_i}))
            $error("cache_bus_arbiter: accepted request with unknown ci/wt");
    end
`endif

endmodule
